// File: rtl/pixel_write_master_pkg.sv
// Shared constants, state encoding and helpers for the pixel write master.
package pixel_write_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int          DEF_SCREEN_W = 320;
  localparam int          DEF_SCREEN_H = 240;
  localparam logic [31:0] DEF_FB_BASE  = 32'h1000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] x;
  } pixel_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic en);
    return (en && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  endfunction

endpackage

// File: rtl/pixel_write_master_fifo.sv
// Pixel FIFO: synchronous, power-of-two depth, push accepted on full when a pop
// happens in the same cycle.
module pixel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pixel_write_master.sv
// Clips pixel strobes, queues them and issues one single-byte AXI4-Lite write
// per pixel. States: S_IDLE | wait for a queued pixel, pop it
//                    S_SEND | AW/W handshakes pending (independent)
//                    S_RESP | BREADY high, waiting for the write response
module pixel_write_master
  import pixel_write_master_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SCREEN_W   = DEF_SCREEN_W,
  parameter int                    SCREEN_H   = DEF_SCREEN_H,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE    = ADDR_WIDTH'(DEF_FB_BASE),
  parameter int                    FIFO_DEPTH = 8,
  parameter logic [7:0]            COLOR      = 8'hFF
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [15:0]               xAddr,
  input  logic [15:0]               yAddr,
  input  logic                      Write,
  input  logic                      CntClear,
  output logic [ADDR_WIDTH-1:0]     oAWADDR,
  output logic [2:0]                oAWPROT,
  output logic                      oAWVALID,
  input  logic                      oAWREADY,
  output logic [DATA_WIDTH-1:0]     oWDATA,
  output logic [DATA_WIDTH/8-1:0]   oWSTRB,
  output logic                      oWVALID,
  input  logic                      oWREADY,
  input  logic [1:0]                oBRESP,
  input  logic                      oBVALID,
  output logic                      oBREADY,
  output logic                      Idle,
  output logic [7:0]                ClipCnt,
  output logic [7:0]                DropCnt,
  output logic [7:0]                ErrCnt
);
  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(STRB_W);

  state_t                  state, state_n;
  logic                    aw_valid_n, w_valid_n, b_ready_n;
  logic [ADDR_WIDTH-1:0]   awaddr_n, addr_calc, lin;
  logic [STRB_W-1:0]       wstrb_n, strb_calc;
  logic signed [31:0]      x_s, y_s;
  logic                    in_range, push, pop, full, empty;
  logic                    clip_hit, drop_hit, err_hit;
  pixel_t                  head;

  assign x_s      = 32'(signed'(xAddr));
  assign y_s      = 32'(signed'(yAddr));
  assign in_range = (x_s >= 0) && (x_s < SCREEN_W) && (y_s >= 0) && (y_s < SCREEN_H);
  assign clip_hit = Write & ~in_range;
  assign push     = Write & in_range & (~full | pop);
  assign drop_hit = Write & in_range & full & ~pop;

  pixel_fifo #(.WIDTH($bits(pixel_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (push),
    .pop   (pop),
    .wdata ({yAddr, xAddr}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Queued coordinates are already clipped, so zero extension is safe.
  assign lin       = ADDR_WIDTH'(head.y) * ADDR_WIDTH'(SCREEN_W) + ADDR_WIDTH'(head.x);
  assign addr_calc = FB_BASE + lin;
  assign strb_calc = STRB_W'(1) << addr_calc[LANE_BITS-1:0];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= S_IDLE;
      oAWVALID <= 1'b0;
      oWVALID  <= 1'b0;
      oBREADY  <= 1'b0;
      oAWADDR  <= '0;
      oWSTRB   <= '0;
    end else begin
      state    <= state_n;
      oAWVALID <= aw_valid_n;
      oWVALID  <= w_valid_n;
      oBREADY  <= b_ready_n;
      oAWADDR  <= awaddr_n;
      oWSTRB   <= wstrb_n;
    end
  end

  always_comb begin
    state_n    = state;
    aw_valid_n = oAWVALID;
    w_valid_n  = oWVALID;
    b_ready_n  = oBREADY;
    awaddr_n   = oAWADDR;
    wstrb_n    = oWSTRB;
    pop        = 1'b0;
    err_hit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          awaddr_n   = addr_calc;
          wstrb_n    = strb_calc;
          aw_valid_n = 1'b1;
          w_valid_n  = 1'b1;
          state_n    = S_SEND;
        end
      end
      S_SEND: begin
        if (oAWREADY) aw_valid_n = 1'b0;
        if (oWREADY)  w_valid_n  = 1'b0;
        if (!aw_valid_n && !w_valid_n) begin
          b_ready_n = 1'b1;
          state_n   = S_RESP;
        end
      end
      S_RESP: begin
        if (oBVALID) begin
          b_ready_n = 1'b0;
          err_hit   = (oBRESP != RESP_OKAY);
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ClipCnt <= '0;
      DropCnt <= '0;
      ErrCnt  <= '0;
    end else if (CntClear) begin
      ClipCnt <= '0;
      DropCnt <= '0;
      ErrCnt  <= '0;
    end else begin
      ClipCnt <= sat_inc(ClipCnt, clip_hit);
      DropCnt <= sat_inc(DropCnt, drop_hit);
      ErrCnt  <= sat_inc(ErrCnt, err_hit);
    end
  end

  assign oAWPROT = 3'b000;
  assign oWDATA  = {STRB_W{COLOR}};
  // Reset forces Idle high even if a strobe arrives while held in reset.
  assign Idle    = ~ARESETn | (empty & (state == S_IDLE) & ~(Write & in_range));

endmodule

// File: tb/tb_pixel_write_master.sv
// Bench for pixel_write_master: directed vectors, multi-cycle corner sequences
// and a randomized run scored against a queue-based reference model.
module tb_pixel_write_master;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [15:0] xAddr, yAddr;
  logic        Write, CntClear;
  logic [31:0] oAWADDR;
  logic [2:0]  oAWPROT;
  logic        oAWVALID, oAWREADY;
  logic [31:0] oWDATA;
  logic [3:0]  oWSTRB;
  logic        oWVALID, oWREADY;
  logic [1:0]  oBRESP;
  logic        oBVALID, oBREADY;
  logic        Idle;
  logic [7:0]  ClipCnt, DropCnt, ErrCnt;

  always #5 ACLK = ~ACLK;

  pixel_write_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .xAddr(xAddr), .yAddr(yAddr), .Write(Write),
    .CntClear(CntClear), .oAWADDR(oAWADDR), .oAWPROT(oAWPROT), .oAWVALID(oAWVALID),
    .oAWREADY(oAWREADY), .oWDATA(oWDATA), .oWSTRB(oWSTRB), .oWVALID(oWVALID),
    .oWREADY(oWREADY), .oBRESP(oBRESP), .oBVALID(oBVALID), .oBREADY(oBREADY),
    .Idle(Idle), .ClipCnt(ClipCnt), .DropCnt(DropCnt), .ErrCnt(ErrCnt)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] aw_q[$];
  logic [3:0]  w_q[$];
  int  exp_err = 0, outstanding = 0, hs_cnt = 0;
  bit  mon_en = 1'b0;
  bit  prev_aw_wait = 1'b0, prev_w_wait = 1'b0;
  logic [31:0] prev_addr;
  logic [3:0]  prev_strb;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    bit          acc;
    logic [31:0] addr;
    logic [3:0]  strb;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit on_screen(input logic [15:0] x, input logic [15:0] y);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    return (xi >= 0) && (xi < 320) && (yi >= 0) && (yi < 240);
  endfunction

  function automatic logic [31:0] ref_addr(input logic [15:0] x, input logic [15:0] y);
    return 32'h1000_0000 + 32'(int'(y) * 320 + int'(x));
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] a);
    return 4'(1 << int'(a % 32'd4));
  endfunction

  task automatic pulse(input logic [15:0] x, input logic [15:0] y, input bit acc,
                       input logic [31:0] addr, input logic [3:0] strb);
    xAddr = x;
    yAddr = y;
    Write = 1'b1;
    if (acc) begin
      aw_q.push_back(addr);
      w_q.push_back(strb);
      outstanding++;
    end
    tick();
    Write = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(Idle && aw_q.size() == 0 && w_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, Idle && aw_q.size() == 0 && w_q.size() == 0, 1);
  endtask

  task automatic wait_bready(input int budget, input string name);
    int n = 0;
    while (!oBREADY && n < budget) begin
      tick();
      n++;
    end
    check(name, oBREADY, 1);
  endtask

  // Bus monitor: ordering, payload and VALID-stability checks against the queues.
  always @(negedge ACLK) begin
    if (!mon_en) begin
      prev_aw_wait = 1'b0;
      prev_w_wait  = 1'b0;
    end else begin
      if (prev_aw_wait) begin
        check("aw_hold", oAWVALID, 1);
        check("aw_addr_stable", oAWADDR, prev_addr);
      end
      if (prev_w_wait) begin
        check("w_hold", oWVALID, 1);
        check("w_strb_stable", oWSTRB, prev_strb);
      end
      if (oAWVALID && oAWREADY) begin
        hs_cnt++;
        check("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) check("aw_addr", oAWADDR, aw_q.pop_front());
      end
      if (oWVALID && oWREADY) begin
        check("w_expected", w_q.size() != 0, 1);
        check("w_data", oWDATA, 32'hFFFF_FFFF);
        if (w_q.size() != 0) check("w_strb", oWSTRB, w_q.pop_front());
      end
      if (oBVALID && oBREADY) begin
        if (oBRESP != 2'b00) exp_err++;
        if (outstanding > 0) outstanding--;
      end
      prev_aw_wait = oAWVALID && !oAWREADY;
      prev_w_wait  = oWVALID && !oWREADY;
      prev_addr    = oAWADDR;
      prev_strb    = oWSTRB;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int exp_clip, hs0;
    logic [15:0] rx, ry;

    ARESETn = 1'b0; xAddr = '0; yAddr = '0; Write = 1'b0; CntClear = 1'b0;
    oAWREADY = 1'b0; oWREADY = 1'b0; oBRESP = 2'b00; oBVALID = 1'b0;
    repeat (3) tick();
    check("rst_awvalid", oAWVALID, 0);
    check("rst_wvalid", oWVALID, 0);
    check("rst_bready", oBREADY, 0);
    check("rst_awaddr", oAWADDR, 0);
    check("rst_wstrb", oWSTRB, 0);
    check("rst_idle", Idle, 1);
    check("rst_cnts", {ClipCnt, DropCnt, ErrCnt}, 0);
    check("awprot", oAWPROT, 0);
    ARESETn = 1'b1;
    mon_en  = 1'b1;

    // Single pixel, zero-wait slave: AWVALID in cycle 2.
    oAWREADY = 1'b1; oWREADY = 1'b1; oBVALID = 1'b1; oBRESP = 2'b00;
    xAddr = 16'd5; yAddr = 16'd2; Write = 1'b1;
    aw_q.push_back(32'h1000_0285); w_q.push_back(4'b0010); outstanding++;
    #1 check("idle_low_on_write", Idle, 0);
    tick(); Write = 1'b0;
    check("t1_c1_awvalid", oAWVALID, 0);
    tick();
    check("t1_awvalid", oAWVALID, 1);
    check("t1_wvalid", oWVALID, 1);
    check("t1_awaddr", oAWADDR, 32'h1000_0285);
    check("t1_wstrb", oWSTRB, 4'b0010);
    check("t1_wdata", oWDATA, 32'hFFFF_FFFF);
    tick();
    check("t1_bready", oBREADY, 1);
    tick();
    check("t1_bready_drop", oBREADY, 0);
    check("t1_idle", Idle, 1);

    // Clip / address table.
    vecs[0] = '{16'd320,  16'd0,   1'b0, 32'h0,          4'h0};
    vecs[1] = '{16'hFFFF, 16'd10,  1'b0, 32'h0,          4'h0};
    vecs[2] = '{16'd0,    16'd240, 1'b0, 32'h0,          4'h0};
    vecs[3] = '{16'd319,  16'd239, 1'b1, 32'h1001_2BFF, 4'b1000};
    vecs[4] = '{16'd0,    16'd0,   1'b1, 32'h1000_0000, 4'b0001};
    vecs[5] = '{16'h8000, 16'd5,   1'b0, 32'h0,          4'h0};
    vecs[6] = '{16'd7,    16'hFFFE, 1'b0, 32'h0,         4'h0};
    vecs[7] = '{16'd100,  16'd100, 1'b1, 32'h1000_7D64, 4'b0001};
    vecs[8] = '{16'd319,  16'd240, 1'b0, 32'h0,          4'h0};
    exp_clip = 0;
    for (int i = 0; i < 9; i++) begin
      pulse(vecs[i].x, vecs[i].y, vecs[i].acc, vecs[i].addr, vecs[i].strb);
      if (!vecs[i].acc) exp_clip++;
      wait_idle(20, "tbl_idle");
      check("tbl_clipcnt", ClipCnt, exp_clip);
    end

    // Overflow: stalled slave, 10 back-to-back writes.
    oAWREADY = 1'b0; oWREADY = 1'b0; oBVALID = 1'b0;
    hs0 = hs_cnt;
    for (int i = 0; i < 10; i++)
      pulse(16'(i), 16'd1, i < 9, ref_addr(16'(i), 16'd1), ref_strb(ref_addr(16'(i), 16'd1)));
    check("ovf_dropcnt", DropCnt, 1);
    check("ovf_busy", Idle, 0);
    oAWREADY = 1'b1; oWREADY = 1'b1; oBVALID = 1'b1;
    wait_idle(80, "ovf_drain");
    check("ovf_writes", hs_cnt - hs0, 9);

    // Split handshake: W accepted three cycles before AW.
    oAWREADY = 1'b0; oWREADY = 1'b0; oBVALID = 1'b0;
    pulse(16'd10, 16'd3, 1'b1, ref_addr(16'd10, 16'd3), ref_strb(ref_addr(16'd10, 16'd3)));
    tick();
    check("split_aw_up", oAWVALID, 1);
    check("split_w_up", oWVALID, 1);
    oWREADY = 1'b1; tick(); oWREADY = 1'b0;
    check("split_w_drop", oWVALID, 0);
    check("split_aw_held", oAWVALID, 1);
    check("split_no_bready", oBREADY, 0);
    tick(); tick();
    check("split_aw_held2", oAWVALID, 1);
    check("split_addr", oAWADDR, 32'h1000_03CA);
    check("split_no_bready2", oBREADY, 0);
    oAWREADY = 1'b1; tick(); oAWREADY = 1'b0;
    check("split_aw_drop", oAWVALID, 0);
    check("split_bready", oBREADY, 1);
    oBVALID = 1'b1; tick(); oBVALID = 1'b0;
    check("split_bready_drop", oBREADY, 0);
    check("split_idle", Idle, 1);

    // Error response, no retry, clear beats increment.
    oAWREADY = 1'b1; oWREADY = 1'b1; oBVALID = 1'b0;
    CntClear = 1'b1; tick(); CntClear = 1'b0;
    check("clr_drop", DropCnt, 0);
    hs0 = hs_cnt;
    pulse(16'd20, 16'd4, 1'b1, ref_addr(16'd20, 16'd4), ref_strb(ref_addr(16'd20, 16'd4)));
    pulse(16'd21, 16'd4, 1'b1, ref_addr(16'd21, 16'd4), ref_strb(ref_addr(16'd21, 16'd4)));
    wait_bready(20, "err_bready1");
    oBVALID = 1'b1; oBRESP = 2'b10; tick(); oBVALID = 1'b0; oBRESP = 2'b00;
    check("err_cnt_1", ErrCnt, 1);
    wait_bready(20, "err_bready2");
    oBVALID = 1'b1; oBRESP = 2'b11; CntClear = 1'b1;
    tick();
    oBVALID = 1'b0; oBRESP = 2'b00; CntClear = 1'b0;
    check("err_clear_prio", ErrCnt, 0);
    wait_idle(20, "err_idle");
    check("err_no_retry", hs_cnt - hs0, 2);

    // Reset in S_SEND with four pixels queued.
    oAWREADY = 1'b0; oWREADY = 1'b0; oBVALID = 1'b0;
    pulse(16'hFFFF, 16'd0, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++)
      pulse(16'(30 + i), 16'd7, 1'b1, ref_addr(16'(30 + i), 16'd7), ref_strb(ref_addr(16'(30 + i), 16'd7)));
    check("rst_pre_aw", oAWVALID, 1);
    check("rst_pre_clip", ClipCnt, 1);
    mon_en = 1'b0; ARESETn = 1'b0;
    #1;
    check("rmid_awvalid", oAWVALID, 0);
    check("rmid_wvalid", oWVALID, 0);
    check("rmid_bready", oBREADY, 0);
    check("rmid_idle", Idle, 1);
    check("rmid_cnts", {ClipCnt, DropCnt, ErrCnt}, 0);
    aw_q.delete(); w_q.delete(); outstanding = 0;
    tick();
    ARESETn = 1'b1; mon_en = 1'b1;
    oAWREADY = 1'b1; oWREADY = 1'b1; oBVALID = 1'b1;
    hs0 = hs_cnt;
    repeat (20) tick();
    check("rmid_no_stale", hs_cnt - hs0, 0);
    check("rmid_idle_after", Idle, 1);

    // Randomized traffic against the queue model; outstanding capped so no drops.
    CntClear = 1'b1; tick(); CntClear = 1'b0;
    exp_clip = 0; exp_err = 0; outstanding = 0;
    for (int c = 0; c < 1500; c++) begin
      oAWREADY = 1'($urandom_range(0, 1));
      oWREADY  = 1'($urandom_range(0, 1));
      oBVALID  = 1'($urandom_range(0, 1));
      oBRESP   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0 && outstanding < 8) begin
        rx = 16'($urandom_range(0, 359)) - 16'd20;
        ry = 16'($urandom_range(0, 279)) - 16'd20;
        if (on_screen(rx, ry)) begin
          pulse(rx, ry, 1'b1, ref_addr(rx, ry), ref_strb(ref_addr(rx, ry)));
        end else begin
          if (exp_clip < 255) exp_clip++;
          pulse(rx, ry, 1'b0, 32'h0, 4'h0);
        end
      end else begin
        tick();
      end
    end
    oAWREADY = 1'b1; oWREADY = 1'b1; oBVALID = 1'b1; oBRESP = 2'b00;
    wait_idle(120, "rand_drain");
    check("rand_clipcnt", ClipCnt, exp_clip);
    check("rand_dropcnt", DropCnt, 0);
    check("rand_errcnt", ErrCnt, (exp_err > 255) ? 255 : exp_err);

    // Saturation of the clip counter.
    CntClear = 1'b1; tick(); CntClear = 1'b0;
    for (int i = 0; i < 260; i++) pulse(16'd400, 16'd0, 1'b0, 32'h0, 4'h0);
    check("clip_saturate", ClipCnt, 255);
    check("sat_no_write", aw_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
